// File: rtl/pipelined_subtractor.sv
// rtl/pipelined_subtractor.sv - S-stage sliced subtractor (op1 - op2 - bin) with rippled borrow
// and a ready/valid output handshake; the whole pipeline freezes under backpressure.
module pipelined_subtractor #(
   parameter int W = 128,
   parameter int S = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [W-1:0] op1,
   input  logic [W-1:0] op2,
   input  logic         bin,
   input  logic         valid_op1,
   input  logic         valid_op2,
   output logic         in_ready,
   output logic [W-1:0] res,
   output logic         bout,
   output logic         ovf,
   output logic         valid,
   input  logic         res_ready
);

   localparam int SW = W / S;

   if (W % S != 0) begin : g_bad_width
      $error("pipelined_subtractor: W must be a multiple of S");
   end

   logic         en;
   logic [W-1:0] a_q   [S];
   logic [W-1:0] b_q   [S];
   logic [W-1:0] p_q   [S];
   logic         br_q  [S];
   logic         v_q   [S];
   logic [SW:0]  d     [S];
   logic [W-1:0] p_nxt [S];

   assign en       = res_ready | ~valid;
   assign in_ready = en;

   // Each stage replaces its own slice in the forwarded partial result; the
   // extra top bit of the widened difference is the slice borrow-out.
   always_comb begin
      for (int k = 0; k < S; k++) begin
         d[k]     = {1'b0, a_q[k][k*SW +: SW]} - {1'b0, b_q[k][k*SW +: SW]}
                    - {{SW{1'b0}}, br_q[k]};
         p_nxt[k] = p_q[k];
         p_nxt[k][k*SW +: SW] = d[k][SW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < S; k++) begin
            a_q[k]  <= '0;
            b_q[k]  <= '0;
            p_q[k]  <= '0;
            br_q[k] <= 1'b0;
            v_q[k]  <= 1'b0;
         end
         res   <= '0;
         bout  <= 1'b0;
         ovf   <= 1'b0;
         valid <= 1'b0;
      end else if (en) begin
         a_q[0]  <= op1;
         b_q[0]  <= op2;
         p_q[0]  <= '0;
         br_q[0] <= bin;
         v_q[0]  <= valid_op1 & valid_op2;
         for (int k = 1; k < S; k++) begin
            a_q[k]  <= a_q[k-1];
            b_q[k]  <= b_q[k-1];
            p_q[k]  <= p_nxt[k-1];
            br_q[k] <= d[k-1][SW];
            v_q[k]  <= v_q[k-1];
         end
         valid <= v_q[S-1];
         // Output data only moves with a real result so it holds across bubbles.
         if (v_q[S-1]) begin
            res  <= p_nxt[S-1];
            bout <= d[S-1][SW];
            ovf  <= (a_q[S-1][W-1] != b_q[S-1][W-1]) & (p_nxt[S-1][W-1] != a_q[S-1][W-1]);
         end
      end
   end

endmodule

// File: tb/tb_pipelined_subtractor.sv
// tb/tb_pipelined_subtractor.sv - directed-vector bench for pipelined_subtractor (W=128, S=4).
module tb_pipelined_subtractor;

   localparam int W = 128;
   localparam int S = 4;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic [W-1:0] op1 = '0;
   logic [W-1:0] op2 = '0;
   logic         bin = 1'b0;
   logic         valid_op1 = 1'b0;
   logic         valid_op2 = 1'b0;
   logic         in_ready;
   logic [W-1:0] res;
   logic         bout;
   logic         ovf;
   logic         valid;
   logic         res_ready = 1'b1;

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] ones;
   logic [W-1:0] msb;
   logic [W-1:0] max_pos;
   logic [W-1:0] held;
   logic [W-1:0] exp_q [$];
   int           idx;
   int           retired;
   logic         acc;

   pipelined_subtractor #(.W(W), .S(S)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .op1       (op1),
      .op2       (op2),
      .bin       (bin),
      .valid_op1 (valid_op1),
      .valid_op2 (valid_op2),
      .in_ready  (in_ready),
      .res       (res),
      .bout      (bout),
      .ovf       (ovf),
      .valid     (valid),
      .res_ready (res_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Single operation on an idle pipeline with res_ready held high; entered at posedge+1.
   task automatic one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic bi, input logic [W-1:0] er, input logic eb, input logic eo);
      int lat;
      op1 = a; op2 = b; bin = bi;
      valid_op1 = 1'b1; valid_op2 = 1'b1;
      @(posedge clk); #1;
      valid_op1 = 1'b0; valid_op2 = 1'b0;
      lat = 0;
      while (!valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, W'(lat), W'(S));
      check({tag, " res"}, res, er);
      check({tag, " bout"}, W'(bout), W'(eb));
      check({tag, " ovf"}, W'(ovf), W'(eo));
      @(posedge clk); #1;
      check({tag, " valid drop"}, W'(valid), '0);
   endtask

   initial begin
      ones    = '1;
      msb     = {1'b1, {(W-1){1'b0}}};
      max_pos = {1'b0, {(W-1){1'b1}}};

      @(posedge clk); #1;
      check("reset valid", W'(valid), '0);
      check("reset res", res, '0);
      check("reset bout_ovf", W'({bout, ovf}), '0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check("release in_ready", W'(in_ready), W'(1));
      @(posedge clk); #1;

      one("sub5_3", W'(5), W'(3), 1'b0, W'(2), 1'b0, 1'b0);
      one("sub0_1", '0, W'(1), 1'b0, ones, 1'b1, 1'b0);
      one("slice_borrow", W'(64'h1_0000_0000), '0, 1'b1, W'(32'hFFFF_FFFF), 1'b0, 1'b0);
      one("minneg_1", msb, W'(1), 1'b0, max_pos, 1'b0, 1'b1);
      one("maxpos_m1", max_pos, ones, 1'b0, msb, 1'b1, 1'b1);

      // Back-to-back: accept in iteration j shows up after the edge of iteration j+4.
      res_ready = 1'b1;
      for (int j = 0; j < 14; j++) begin
         if (j < 8) begin
            op1 = W'(j + 10); op2 = W'(j); bin = 1'b0;
            valid_op1 = 1'b1; valid_op2 = 1'b1;
         end else begin
            valid_op1 = 1'b0; valid_op2 = 1'b0;
         end
         check("b2b in_ready", W'(in_ready), W'(1));
         @(posedge clk); #1;
         check("b2b valid", W'(valid), W'(j >= 4 && j < 12));
         if (j >= 4 && j < 12) check("b2b res", res, W'(10));
      end

      // Stream with a 3-cycle stall; scoreboard sampled on the falling edge.
      idx = 0; retired = 0; held = '0;
      for (int t = 0; t < 30; t++) begin
         valid_op1 = (idx < 10); valid_op2 = (idx < 10);
         op1 = W'(1000 + idx * 3); op2 = W'(idx); bin = idx[0];
         res_ready = !(t >= 6 && t <= 8);
         @(negedge clk);
         acc = valid_op1 && valid_op2 && in_ready;
         if (acc) exp_q.push_back(W'(1000 + 2 * idx) - W'(idx[0]));
         if (!res_ready) begin
            check("stall valid", W'(valid), W'(1));
            check("stall in_ready", W'(in_ready), '0);
            if (t == 6) held = res;
            else check("stall hold", res, held);
         end else if (valid) begin
            check("stream nonempty", W'(exp_q.size() != 0), W'(1));
            if (exp_q.size() != 0) check("stream res", res, exp_q.pop_front());
            retired++;
         end
         @(posedge clk); #1;
         if (acc) idx++;
      end
      check("stream retired", W'(retired), W'(10));
      check("stream leftover", W'(exp_q.size()), '0);

      // One operand valid alone is never accepted.
      res_ready = 1'b1;
      valid_op1 = 1'b1; valid_op2 = 1'b0; op1 = W'(77); op2 = W'(7);
      for (int j = 0; j < 8; j++) begin
         @(posedge clk); #1;
         check("half valid", W'(valid), '0);
      end
      valid_op1 = 1'b0;

      // Three ops in flight, then asynchronous reset between clock edges.
      for (int i = 0; i < 3; i++) begin
         op1 = max_pos; op2 = ones - W'(i); bin = 1'b0;
         valid_op1 = 1'b1; valid_op2 = 1'b1;
         @(posedge clk); #1;
      end
      valid_op1 = 1'b0; valid_op2 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #3;
      check("pre-rst valid", W'(valid), W'(1));
      check("pre-rst res", res, msb);
      check("pre-rst bout_ovf", W'({bout, ovf}), W'(3));
      rstn = 1'b0;
      #1;
      check("async rst valid", W'(valid), '0);
      check("async rst res", res, '0);
      check("async rst bout", W'(bout), '0);
      check("async rst ovf", W'(ovf), '0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check("post-rst in_ready", W'(in_ready), W'(1));
      for (int j = 0; j < 8; j++) begin
         @(posedge clk); #1;
         check("post-rst no ghost", W'(valid), '0);
      end
      one("post-rst op", W'(5), W'(3), 1'b0, W'(2), 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipelined_subtractor.md
Name: pipelined_subtractor

Overview:
- Pipelined W-bit subtractor computing op1 − op2 − bin over S equal slices, with a borrow rippled stage to stage. It is the inverse-operation companion to the team's pipelined carry-lookahead adder.
- Same operand/valid front end as the adder. Adds a ready/valid output handshake with backpressure, so it can feed consumers that stall.
- Sits in the datapath next to the adder. Used for compare, decrement and difference operations on wide operands.

Parameters:
- W, 128: data width in bits; W % S must be 0, otherwise elaboration fails.
- S, 4: number of pipeline stages; each slice is W/S bits.

Ports:
- clk, input, 1: clock, rising edge.
- rstn, input, 1: asynchronous active-low reset.
- op1, input, W: minuend.
- op2, input, W: subtrahend.
- bin, input, 1: borrow in.
- valid_op1, input, 1: op1 valid.
- valid_op2, input, 1: op2 valid.
- in_ready, output, 1: block can accept an operand pair this cycle.
- res, output, W: difference.
- bout, output, 1: final borrow out (unsigned underflow).
- ovf, output, 1: signed overflow.
- valid, output, 1: res/bout/ovf hold a result.
- res_ready, input, 1: consumer accepts the result.

Behaviour:
- Accept: a transaction is accepted on a rising edge when valid_op1 & valid_op2 & in_ready. If only one operand valid is high, nothing is accepted.
- Pipeline enable: en = res_ready | ~valid, and in_ready = en (combinational).
- Stall: when en = 0 the whole pipeline freezes. This includes operand copies, partial results, borrows and per-stage valid bits.
- Bubbles are not collapsed. Behaviour is fully deterministic.
- Stage k (k = 0..S−1) subtracts slice k, bits [k*W/S +: W/S], of its registered operands.
  - Borrow into stage 0 is the registered bin.
  - Borrow into stage k>0 is the registered borrow-out of stage k−1.
  - Each stage passes forward: the full operands (for later slices), the completed low slices, the slice borrow, and a valid bit.
- Output register: stage S−1's result loads res/bout/ovf/valid.
- Latency: a transaction accepted at edge E0 shows valid = 1 after edge E0+S, given no stalls. Each stall cycle adds one cycle.
- Throughput: 1 result per cycle while res_ready stays high.
- Arithmetic:
  - res = (op1 − op2 − bin) mod 2^W.
  - bout = 1 iff op1 < op2 + bin, unsigned; this equals the borrow out of the top slice.
  - ovf = (op1[W−1] != op2[W−1]) & (res[W−1] != op1[W−1]).
- Output hold: while valid = 1 and res_ready = 0, res/bout/ovf/valid stay stable. A result is never dropped or duplicated.
- Result retirement: a result retires on an edge where valid & res_ready.
  - If no new result arrives from stage S−1 on that edge, valid drops to 0.
  - Output data may hold its last value while valid = 0.
- Reset:
  - rstn low asynchronously clears all stage valid bits, res = 0, bout = 0, ovf = 0, valid = 0. Stage data registers are cleared to 0.
  - In-flight transactions are discarded; none appears after reset releases.
  - in_ready = 1 in the first cycle after release.
- Simultaneous retire and accept on the same edge is allowed and loses no data.
- Operands may change freely when not accepted.

Test Plan (W=128, S=4):
- op1=5, op2=3, bin=0, both valids high one cycle, res_ready=1 -> valid high exactly 4 edges later; res=2, bout=0, ovf=0; valid low next cycle.
- op1=0, op2=1, bin=0 -> res=all ones, bout=1, ovf=0; borrow ripples through all 4 slices. Also op1=0x1_0000_0000, op2=0, bin=1 -> res=0xFFFF_FFFF, bout=0.
- op1=0x8000…0, op2=1 -> res=0x7FFF…F, ovf=1, bout=0. Then op1=0x7FFF…F, op2=0xFFFF…F -> res=0x8000…0, ovf=1, bout=1.
- 8 back-to-back ops (op1=i+10, op2=i, i=0..7), res_ready=1 -> valid high 8 consecutive cycles, res=10 each, in order; in_ready stays 1.
- Stream running, res_ready low 3 cycles while valid=1 -> in_ready=0, res stable over those 3 cycles. After release, all results arrive in order with none lost or duplicated. Also valid_op1=1, valid_op2=0 -> no result produced.
- Three ops in flight, rstn pulsed low mid-cycle -> valid/res/bout/ovf go to 0 immediately without waiting for a clock edge; no result emerges after release; the next op completes with normal 4-cycle latency.
